// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for a 256x8 asynchronous RAM: picks a winner,
// sequences setup/strobe/hold and registers every RAM control output.
// Optional build macro: RAM_ARB_ROUND_ROBIN_EN (round-robin instead of fixed A priority).
module ram_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int WR_PULSE = 1
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_reqA,
    input  logic              i_reqB,
    input  logic              i_weA,
    input  logic              i_weB,
    input  logic [ADDR_W-1:0] i_addrA,
    input  logic [ADDR_W-1:0] i_addrB,
    input  logic [DATA_W-1:0] i_wdataA,
    input  logic [DATA_W-1:0] i_wdataB,
    output logic              o_ackA,
    output logic              o_ackB,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_ram_writeNEn,
    output logic              o_ram_noe,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_busy,
    output logic              o_grantB
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

    localparam logic [3:0] PULSE_LAST = 4'(WR_PULSE - 1);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_pulse_cnt;
    logic              r_we;
    logic              w_req_any;
    logic              w_grant_b;
    logic              w_we_sel;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [DATA_W-1:0] w_wdata_sel;
    logic              w_start;

    assign w_req_any = i_reqA | i_reqB;
    assign w_start   = (r_state == S_IDLE) && w_req_any;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic r_last_b;

    // On a tie the port that was not served last wins.
    assign w_grant_b = i_reqB & (~i_reqA | ~r_last_b);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_last_b <= 1'b1;
        end else if (w_start) begin
            r_last_b <= w_grant_b;
        end
    end
`else
    assign w_grant_b = i_reqB & ~i_reqA;
`endif

    assign w_we_sel    = w_grant_b ? i_weB    : i_weA;
    assign w_addr_sel  = w_grant_b ? i_addrB  : i_addrA;
    assign w_wdata_sel = w_grant_b ? i_wdataB : i_wdataA;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default before the case so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_req_any) w_next = S_SETUP;
            S_SETUP:  w_next = r_we ? S_STROBE : S_DONE;
            S_STROBE: if (r_pulse_cnt == PULSE_LAST) w_next = S_HOLD;
            S_HOLD:   w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_ackA         <= 1'b0;
            o_ackB         <= 1'b0;
            o_rdata        <= '0;
            o_ram_addr     <= '0;
            o_ram_wdata    <= '0;
            o_ram_writeNEn <= 1'b1;
            o_ram_noe      <= 1'b1;
            o_busy         <= 1'b0;
            o_grantB       <= 1'b0;
            r_we           <= 1'b0;
            r_pulse_cnt    <= '0;
        end else begin
            o_busy         <= (w_next != S_IDLE);
            o_ram_writeNEn <= (w_next != S_STROBE);
            o_ram_noe      <= !(w_start && !w_we_sel);
            o_ackA         <= (w_next == S_DONE) && !o_grantB;
            o_ackB         <= (w_next == S_DONE) && o_grantB;

            if (w_start) begin
                o_grantB    <= w_grant_b;
                o_ram_addr  <= w_addr_sel;
                o_ram_wdata <= w_wdata_sel;
                r_we        <= w_we_sel;
            end else if (w_next == S_IDLE) begin
                o_grantB <= 1'b0;
            end

            if (r_state == S_SETUP && !r_we) begin
                o_rdata <= i_ram_rdata;
            end

            r_pulse_cnt <= (r_state == S_STROBE) ? r_pulse_cnt + 4'd1 : 4'd0;
        end
    end

endmodule
